// File: rtl/dm_arb_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
package dm_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 12;
    localparam int unsigned DATA_W_DEF = 32;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } dm_arb_state_t;

    // Captured command of the granted port
    typedef struct packed {
        logic                  we;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
    } dm_req_t;

    // One-hot port mask for a 2-port index
    function automatic logic [1:0] port_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dm_port_arbiter_if.sv
// Request/response channels of the two requesters facing the arbiter.
interface dm_port_arbiter_if
    import dm_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);

    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [1:0]             req_we;
    logic [1:0][ADDR_W-1:0] req_addr;
    logic [1:0][DATA_W-1:0] req_wdata;
    logic [1:0]             rsp_valid;
    logic [1:0]             rsp_ready;
    logic [DATA_W-1:0]      rsp_rdata;

    // Requester side
    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/dm_rr_pick2.sv
// Combinational two-way round-robin picker: on contention the port that did
// not win last time is chosen.
module dm_rr_pick2
    import dm_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       gnt_idx
);

    // Select the winning index, then expand to a one-hot grant
    always_comb begin
        gnt_idx = 1'b0;
        gnt     = 2'b00;
        case (req)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = ~last;
            default: gnt_idx = 1'b0;
        endcase
        if (req != 2'b00) begin
            gnt = port_onehot(gnt_idx);
        end
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// Two-port arbiter and sequencer in front of the single-ported data memory.
// One transaction at a time: IDLE picks and captures, ISSUE strobes the
// memory for one cycle, RESP holds the response until the owner accepts it.
// ADDR_W/DATA_W must not exceed the package widths that size dm_req_t.
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
)
(
    input  logic                  clk,
    input  logic                  rst,
    dm_port_arbiter_if.slave      bus,
    output logic                  DM_enable,
    output logic                  DM_read,
    output logic                  DM_write,
    output logic [ADDR_W-1:0]     DM_address,
    output logic [DATA_W-1:0]     DM_in,
    input  logic [DATA_W-1:0]     DM_out,
    output logic                  busy,
    output logic                  grant_id
);

    dm_arb_state_t state;
    dm_req_t       cmd_q;
    dm_req_t       next_cmd;
    logic          last_grant;
    logic [1:0]    rsp_valid_q;
    logic [1:0]    pick_gnt;
    logic          pick_idx;

    dm_rr_pick2 u_pick (
        .req     (bus.req_valid),
        .last    (last_grant),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx)
    );

    // Command fields of the currently picked port
    always_comb begin
        next_cmd       = '0;
        next_cmd.we    = bus.req_we[pick_idx];
        next_cmd.addr  = ADDR_W_DEF'(bus.req_addr[pick_idx]);
        next_cmd.wdata = DATA_W_DEF'(bus.req_wdata[pick_idx]);
    end

    // Accept only in IDLE; held off during reset so nothing is lost silently
    assign bus.req_ready = (state == IDLE && !rst) ? pick_gnt : 2'b00;

    // Response channel; DM_out is stable in RESP because no strobe is issued
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = (state == RESP && !cmd_q.we) ? DM_out : '0;

    // Address and write data are taken straight from the captured command
    assign DM_address = ADDR_W'(cmd_q.addr);
    assign DM_in      = DATA_W'(cmd_q.wdata);

    // Sequencer FSM with registered strobes, response valid and busy
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            grant_id    <= 1'b0;
            cmd_q       <= '0;
            DM_enable   <= 1'b0;
            DM_read     <= 1'b0;
            DM_write    <= 1'b0;
            rsp_valid_q <= 2'b00;
            busy        <= 1'b0;
        end else begin
            DM_enable <= 1'b0;
            DM_read   <= 1'b0;
            DM_write  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_gnt != 2'b00) begin
                        cmd_q      <= next_cmd;
                        grant_id   <= pick_idx;
                        last_grant <= pick_idx;
                        DM_enable  <= 1'b1;
                        DM_read    <= ~next_cmd.we;
                        DM_write   <= next_cmd.we;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    rsp_valid_q <= port_onehot(grant_id);
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready[grant_id]) begin
                        rsp_valid_q <= 2'b00;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 2'b00;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Scoreboard bench for dm_port_arbiter: directed requests push expected
// responses; a negedge monitor compares whatever the arbiter presents.
module tb_dm_port_arbiter;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          DM_enable;
    logic          DM_read;
    logic          DM_write;
    logic [AW-1:0] DM_address;
    logic [DW-1:0] DM_in;
    logic [DW-1:0] DM_out = '0;
    logic          busy;
    logic          grant_id;

    always #5 clk = ~clk;

    dm_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dm_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .DM_enable  (DM_enable),
        .DM_read    (DM_read),
        .DM_write   (DM_write),
        .DM_address (DM_address),
        .DM_in      (DM_in),
        .DM_out     (DM_out),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    // Memory model: registered read data, held until the next read
    logic [DW-1:0] mem [0:(1<<AW)-1];

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return {20'hA5C30, a};
    endfunction

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = init_val(AW'(i));
    end

    always @(posedge clk) begin
        if (rst) begin
            DM_out <= '0;
        end else if (DM_enable) begin
            if (DM_write) mem[DM_address] <= DM_in;
            if (DM_read)  DM_out <= mem[DM_address];
        end
    end

    // Scoreboard
    typedef struct {
        logic          port;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic expect_rsp(input logic p, input logic [DW-1:0] d);
        exp_t e;
        e.port = p;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Response monitor
    logic          mon_active = 1'b0;
    logic          mon_port   = 1'b0;
    logic [DW-1:0] mon_data   = '0;

    always @(negedge clk) begin
        exp_t e;
        if (bus.rsp_valid != 2'b00) begin
            if (!mon_active) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_port", 64'(bus.rsp_valid), e.port ? 64'd2 : 64'd1);
                    chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.data));
                end
                mon_active = 1'b1;
                mon_port   = bus.rsp_valid[1];
                mon_data   = bus.rsp_rdata;
            end else begin
                chk("rsp_hold_valid", 64'(bus.rsp_valid), mon_port ? 64'd2 : 64'd1);
                chk("rsp_hold_data", 64'(bus.rsp_rdata), 64'(mon_data));
            end
            if (bus.rsp_ready[mon_port]) mon_active = 1'b0;
        end else begin
            mon_active = 1'b0;
        end
    end

    // Protocol properties sampled every cycle
    always @(negedge clk) begin
        chk("dm_rw_exclusive", 64'(DM_read & DM_write), 64'd0);
        chk("strobe_without_enable", 64'((DM_read | DM_write) & ~DM_enable), 64'd0);
        chk("rsp_valid_onehot0", 64'(bus.rsp_valid == 2'b11), 64'd0);
        chk("ready_while_busy", 64'(busy && (bus.req_ready != 2'b00)), 64'd0);
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    // Present a request and return just after its accepting edge
    task automatic do_req(input logic p, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
        int cyc;
        cyc = 0;
        @(posedge clk); #1;
        bus.req_we[p]    = we;
        bus.req_addr[p]  = a;
        bus.req_wdata[p] = d;
        bus.req_valid[p] = 1'b1;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.req_ready[p] && cyc < 50);
        if (!bus.req_ready[p]) chk("req_accept_timeout", 64'(bus.req_ready[p]), 64'd1);
        @(posedge clk); #1;
        bus.req_valid[p] = 1'b0;
    endtask

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (busy && cyc < 50);
        if (busy) chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        chk({tag, "_dm_strobes"}, 64'({DM_enable, DM_read, DM_write}), 64'd0);
        chk({tag, "_dm_address"}, 64'(DM_address), 64'd0);
        chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
    endtask

    initial begin
        int acc;
        int last_cyc;

        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 2'b11;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk_quiet("reset");
        chk("reset_grant_id", 64'(grant_id), 64'd0);
        chk("reset_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);

        // Port 0 store then load of the same word
        expect_rsp(1'b0, 32'h0);
        do_req(1'b0, 1'b1, 12'h010, 32'hDEADBEEF);
        @(negedge clk);
        chk("st_dm_strobes", 64'({DM_enable, DM_read, DM_write}), 64'b101);
        chk("st_dm_address", 64'(DM_address), 64'h010);
        chk("st_dm_in", 64'(DM_in), 64'hDEADBEEF);
        @(negedge clk);
        chk("st_write_one_cycle", 64'(DM_write), 64'd0);
        wait_idle();

        expect_rsp(1'b0, 32'hDEADBEEF);
        do_req(1'b0, 1'b0, 12'h010, 32'h0);
        @(negedge clk);
        chk("ld_dm_strobes", 64'({DM_enable, DM_read, DM_write}), 64'b110);
        @(negedge clk);
        chk("ld_latency_rsp_valid", 64'(bus.rsp_valid), 64'b01);
        wait_idle();

        // Contention out of reset: grants alternate 0,1,0,1 every 3 cycles
        do_reset();
        expect_rsp(1'b0, init_val(12'h001));
        expect_rsp(1'b1, init_val(12'h002));
        expect_rsp(1'b0, init_val(12'h001));
        expect_rsp(1'b1, init_val(12'h002));
        @(posedge clk); #1;
        bus.req_we       = 2'b00;
        bus.req_addr[0]  = 12'h001;
        bus.req_addr[1]  = 12'h002;
        bus.req_valid    = 2'b11;
        acc      = 0;
        last_cyc = 0;
        for (int cyc = 0; cyc < 60 && acc < 4; cyc++) begin
            @(negedge clk);
            if ((bus.req_ready & bus.req_valid) != 2'b00) begin
                chk("grant_order", 64'(bus.req_ready), (acc % 2 == 1) ? 64'b10 : 64'b01);
                if (acc > 0) chk("grant_spacing", 64'(cyc - last_cyc), 64'd3);
                last_cyc = cyc;
                acc++;
                if (acc == 4) begin
                    @(posedge clk); #1;
                    bus.req_valid = 2'b00;
                end
            end
        end
        chk("grant_count", 64'(acc), 64'd4);
        wait_idle();
        chk("grant_id_held_idle", 64'(grant_id), 64'd1);

        // Port 1 load under response back-pressure, port 0 waiting behind it
        bus.rsp_ready = 2'b01;
        expect_rsp(1'b1, init_val(12'h020));
        expect_rsp(1'b0, init_val(12'h030));
        do_req(1'b1, 1'b0, 12'h020, 32'h0);
        bus.req_we[0]    = 1'b0;
        bus.req_addr[0]  = 12'h030;
        bus.req_valid[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) chk("bp_grant_id", 64'(grant_id), 64'd1);
            chk("bp_req_ready_held", 64'(bus.req_ready), 64'd0);
        end
        @(posedge clk); #1 bus.rsp_ready = 2'b11;
        @(negedge clk);
        chk("bp_ready_at_handshake", 64'(bus.req_ready), 64'd0);
        chk("bp_rsp_still_valid", 64'(bus.rsp_valid), 64'b10);
        @(negedge clk);
        chk("bp_ready_after_handshake", 64'(bus.req_ready), 64'b01);
        @(posedge clk); #1 bus.req_valid[0] = 1'b0;
        @(negedge clk);
        chk("bp_p0_grant_id", 64'(grant_id), 64'd0);
        chk("bp_p0_read", 64'(DM_read), 64'd1);
        wait_idle();

        // Store acknowledge on port 1 at top address, then read back
        expect_rsp(1'b1, 32'h0);
        do_req(1'b1, 1'b1, 12'hFFF, 32'h12345678);
        @(negedge clk);
        chk("top_dm_address", 64'(DM_address), 64'hFFF);
        chk("top_dm_write", 64'(DM_write), 64'd1);
        wait_idle();
        expect_rsp(1'b1, 32'h12345678);
        do_req(1'b1, 1'b0, 12'hFFF, 32'h0);
        wait_idle();

        // Reset during ISSUE: no response ever appears
        do_req(1'b0, 1'b0, 12'h005, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk_quiet("rst_issue");

        // Reset during RESP: response shown once, then dropped
        bus.rsp_ready = 2'b10;
        expect_rsp(1'b0, init_val(12'h005));
        do_req(1'b0, 1'b0, 12'h005, 32'h0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk_quiet("rst_resp");
        bus.rsp_ready = 2'b11;
        repeat (3) @(negedge clk);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
